// File: rtl/ysyx_220066_mdu_ctrl_if.sv
// EX-stage <-> multiply/divide unit request/response bundle.
// master: EX pipeline issuing requests and consuming results; slave: the MDU.
// The result is held by the slave until out_valid && out_ready.
interface ysyx_220066_mdu_ctrl_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic            is_w;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_ready;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, op, is_w, src1, src2, out_ready,
    input  busy, out_valid, result
  );

  modport slave (
    input  start, flush, op, is_w, src1, src2, out_ready,
    output busy, out_valid, result
  );
endinterface

// File: rtl/ysyx_220066_mdu_ctrl.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: 64 cycles (32 for word ops) from start to out_valid; div-by-zero/overflow in 1 cycle.
// Backpressure: result held in DONE until out_ready; start ignored while busy; flush aborts anything.
module ysyx_220066_mdu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,   // active-low, asynchronous
  ysyx_220066_mdu_ctrl_if.slave  mdu
);

  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [6:0]      r_cnt;
  logic [1:0]      r_op;       // funct3[1:0]; funct3[2] is captured by the MUL/DIV state
  logic            r_is_w;
  logic            r_neg_q;    // negate product / quotient
  logic            r_neg_r;    // negate remainder (dividend was negative)
  logic [PW-1:0]   r_mcand;    // multiplicand magnitude, shifted left each step
  logic [PW-1:0]   r_acc;      // product accumulator
  logic [XLEN-1:0] r_mplier;   // multiplier magnitude, shifted right each step
  logic [XLEN-1:0] r_rem;      // partial remainder
  logic [XLEN-1:0] r_quo;      // dividend bits shifting out / quotient bits shifting in
  logic [XLEN-1:0] r_dvsr;     // divisor magnitude
  logic [XLEN-1:0] r_result;

  // Request-side decode
  logic            w_sgn1;
  logic            w_sgn2;
  logic [XLEN-1:0] w_ext1;
  logic [XLEN-1:0] w_ext2;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN-1:0] w_min;
  logic            w_dz;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec;

  // Iteration datapath
  logic [PW-1:0]   w_acc_nxt;
  logic [PW-1:0]   w_prod;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [XLEN-1:0] w_fin_raw;
  logic [XLEN-1:0] w_fin;

  // FSM handshakes
  logic w_accept;
  logic w_step;

  // Extend/sign-split the incoming operands and detect the single-cycle divide cases.
  always_comb begin
    w_sgn1 = 1'b0;
    w_sgn2 = 1'b0;
    case (mdu.op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_sgn1 = 1'b1;
        w_sgn2 = 1'b1;
      end
      3'b010:  w_sgn1 = 1'b1;
      default: ;
    endcase

    w_ext1 = mdu.src1;
    w_ext2 = mdu.src2;
    if (mdu.is_w) begin
      w_ext1 = {{(XLEN-32){w_sgn1 & mdu.src1[31]}}, mdu.src1[31:0]};
      w_ext2 = {{(XLEN-32){w_sgn2 & mdu.src2[31]}}, mdu.src2[31:0]};
    end

    w_neg1 = w_sgn1 & w_ext1[XLEN-1];
    w_neg2 = w_sgn2 & w_ext2[XLEN-1];
    w_mag1 = w_neg1 ? (~w_ext1 + 1'b1) : w_ext1;
    w_mag2 = w_neg2 ? (~w_ext2 + 1'b1) : w_ext2;

    w_min  = mdu.is_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_dz   = mdu.op[2] & (w_ext2 == {XLEN{1'b0}});
    w_ovf  = mdu.op[2] & ~mdu.op[0] & (w_ext1 == w_min) & (&w_ext2);
    w_special = w_dz | w_ovf;

    if (w_dz) begin
      w_spec_raw = mdu.op[1] ? w_ext1 : {XLEN{1'b1}};
    end else begin
      w_spec_raw = mdu.op[1] ? {XLEN{1'b0}} : w_ext1;
    end
    w_spec = mdu.is_w ? {{(XLEN-32){w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
  end

  // One multiply/divide iteration plus the sign-corrected result of the final step.
  always_comb begin
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_prod    = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

    w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
    // When w_ge holds the difference is below the divisor, so XLEN bits suffice.
    w_rem_nxt = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvsr) : w_rem_sh[XLEN-1:0];
    w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    w_q_fin   = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    w_r_fin   = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    if (r_state == S_DIV) begin
      w_fin_raw = r_op[1] ? w_r_fin : w_q_fin;
    end else begin
      w_fin_raw = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
    end
    w_fin = r_is_w ? {{(XLEN-32){w_fin_raw[31]}}, w_fin_raw[31:0]} : w_fin_raw;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush dominates start and out_ready everywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mdu.start && !mdu.flush) begin
          w_accept = 1'b1;
          if (!mdu.op[2]) begin
            w_state_nxt = S_MUL;
          end else if (w_special) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (mdu.flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == 7'd1) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (mdu.flush || mdu.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-cycle iteration and result register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= 7'd0;
      r_op     <= 2'b00;
      r_is_w   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mcand  <= {PW{1'b0}};
      r_acc    <= {PW{1'b0}};
      r_mplier <= {XLEN{1'b0}};
      r_rem    <= {XLEN{1'b0}};
      r_quo    <= {XLEN{1'b0}};
      r_dvsr   <= {XLEN{1'b0}};
      r_result <= {XLEN{1'b0}};
    end else if (w_accept) begin
      r_cnt    <= w_special ? 7'd0 : (mdu.is_w ? 7'd32 : 7'd64);
      r_op     <= mdu.op[1:0];
      r_is_w   <= mdu.is_w;
      r_neg_q  <= w_neg1 ^ w_neg2;
      r_neg_r  <= w_neg1;
      r_mcand  <= {{XLEN{1'b0}}, w_mag1};
      r_acc    <= {PW{1'b0}};
      r_mplier <= w_mag2;
      r_rem    <= {XLEN{1'b0}};
      // Word dividends fit in 32 bits; park them at the top so 32 steps consume them.
      r_quo    <= mdu.is_w ? {w_mag1[31:0], {(XLEN-32){1'b0}}} : w_mag1;
      r_dvsr   <= w_mag2;
      if (w_special) begin
        r_result <= w_spec;
      end
    end else if (w_step) begin
      r_cnt <= r_cnt - 7'd1;
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= {r_mcand[PW-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
      end else begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end
      if (r_cnt == 7'd1) begin
        r_result <= w_fin;
      end
    end else if (mdu.flush) begin
      // Abandoned iteration: drop the count so no stale progress survives.
      r_cnt <= 7'd0;
    end
  end

  assign mdu.busy      = (r_state != S_IDLE);
  assign mdu.out_valid = (r_state == S_DONE);
  assign mdu.result    = r_result;

endmodule

// File: tb/tb_ysyx_220066_mdu_ctrl.sv
// Self-checking bench for ysyx_220066_mdu_ctrl: directed corner cases plus
// randomized operations scored against an arithmetic reference model.
module tb_ysyx_220066_mdu_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ysyx_220066_mdu_ctrl_if #(.XLEN(64)) mdu_if ();

  ysyx_220066_mdu_ctrl #(.XLEN(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mdu   (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RV64M semantics computed with plain wide arithmetic.
  task automatic model(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    bit s1;
    bit s2;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] r;
    logic signed [127:0] pa;
    logic signed [127:0] pb;
    logic signed [127:0] p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin s1 = 1; s2 = 1; end  // MUL MULH DIV REM
      3'd2:                   begin s1 = 1; s2 = 0; end  // MULHSU
      default:                begin s1 = 0; s2 = 0; end  // MULHU DIVU REMU
    endcase
    ea = a;
    eb = b;
    if (w) begin
      ea = s1 ? sx32(a[31:0]) : {32'd0, a[31:0]};
      eb = s2 ? sx32(b[31:0]) : {32'd0, b[31:0]};
    end
    lat = w ? 32 : 64;
    if (!op[2]) begin
      pa = s1 ? {{64{ea[63]}}, ea} : {64'd0, ea};
      pb = s2 ? {{64{eb[63]}}, eb} : {64'd0, eb};
      p  = pa * pb;
      r  = (op == 3'd0) ? p[63:0] : p[127:64];
    end else if (eb == 64'd0) begin
      lat = 0;
      r = op[1] ? ea : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (s1 && eb == 64'hFFFF_FFFF_FFFF_FFFF &&
                 ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      lat = 0;
      r = op[1] ? 64'd0 : ea;
    end else if (s1) begin
      sa = ea;
      sb = eb;
      if (op[1]) r = sa % sb;
      else       r = sa / sb;
    end else begin
      if (op[1]) r = ea % eb;
      else       r = ea / eb;
    end
    res = w ? sx32(r[31:0]) : r;
  endtask

  function automatic logic [63:0] pick();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'h0000_0000_FFFF_FFFF;
      5: return 64'($urandom_range(0, 20));
      6: return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one operation, check latency/busy/result, stall in DONE, then accept.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat,
                        input int stall, input bit noise);
    int cyc;
    bit busy_ok;
    bit stable_ok;
    mdu_if.op        = op;
    mdu_if.is_w      = w;
    mdu_if.src1      = a;
    mdu_if.src2      = b;
    mdu_if.start     = 1'b1;
    mdu_if.out_ready = 1'b0;
    step();
    mdu_if.start = 1'b0;
    busy_ok = 1;
    cyc = 0;
    while (mdu_if.out_valid !== 1'b1 && cyc < 200) begin
      if (mdu_if.busy !== 1'b1) busy_ok = 0;
      if (noise) begin
        mdu_if.start     = 1'($urandom_range(0, 1));
        mdu_if.out_ready = 1'($urandom_range(0, 1));
        mdu_if.op        = 3'($urandom_range(0, 7));
        mdu_if.is_w      = 1'($urandom_range(0, 1));
        mdu_if.src1      = {$urandom, $urandom};
        mdu_if.src2      = {$urandom, $urandom};
      end
      step();
      cyc++;
    end
    mdu_if.out_ready = 1'b0;
    chk($sformatf("%s.latency", tag), 64'(cyc), 64'(lat));
    chk($sformatf("%s.busy_run", tag), {63'd0, busy_ok}, 64'd1);
    chk($sformatf("%s.result", tag), mdu_if.result, exp);
    stable_ok = 1;
    for (int i = 0; i < stall; i++) begin
      step();
      if (mdu_if.out_valid !== 1'b1 || mdu_if.busy !== 1'b1 || mdu_if.result !== exp)
        stable_ok = 0;
    end
    if (stall > 0) chk($sformatf("%s.stall_hold", tag), {63'd0, stable_ok}, 64'd1);
    mdu_if.out_ready = 1'b1;
    step();
    mdu_if.out_ready = 1'b0;
    mdu_if.start     = 1'b0;
    chk($sformatf("%s.released", tag), {62'd0, mdu_if.busy, mdu_if.out_valid}, 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic        r_w;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_exp;
    int          r_lat;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    mdu_if.start = 1'b0;
    mdu_if.flush = 1'b0;
    mdu_if.op = 3'd0;
    mdu_if.is_w = 1'b0;
    mdu_if.src1 = 64'd0;
    mdu_if.src2 = 64'd0;
    mdu_if.out_ready = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst.busy", {63'd0, mdu_if.busy}, 64'd0);
    chk("rst.out_valid", {63'd0, mdu_if.out_valid}, 64'd0);
    chk("rst.result", mdu_if.result, 64'd0);
    step();
    rst = 1'b1;

    // Directed corner cases
    run_op("mul_7x-3", 3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0, 1'b0);
    run_op("mulhu_max", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0, 1'b0);
    run_op("mulhsu_-1x2", 3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 5, 1'b0);
    run_op("divw_ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0, 1'b0);
    run_op("remw_ovf", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0, 0, 1'b0);
    run_op("divu_dz", 3'd5, 1'b0, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0);
    run_op("rem_-7_2", 3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 1'b0);
    run_op("div_-7_2", 3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 5, 1'b1);
    run_op("divuw_13_4", 3'd5, 1'b1, 64'hABCD_0000_0000_000D, 64'd4, 64'd3, 32, 0, 1'b0);

    // Flush mid-multiply: back to IDLE, no result, then a clean restart
    mdu_if.op = 3'd0; mdu_if.is_w = 1'b0; mdu_if.src1 = 64'd5; mdu_if.src2 = 64'd9;
    mdu_if.start = 1'b1;
    step();
    mdu_if.start = 1'b0;
    repeat (20) step();
    mdu_if.flush = 1'b1;
    mdu_if.out_ready = 1'b1;
    step();
    mdu_if.flush = 1'b0;
    mdu_if.out_ready = 1'b0;
    chk("flush_mul.state", {62'd0, mdu_if.busy, mdu_if.out_valid}, 64'd0);
    chk("flush_mul.result_kept", mdu_if.result, 64'd3);
    step();
    chk("flush_mul.no_valid", {63'd0, mdu_if.out_valid}, 64'd0);
    run_op("after_flush", 3'd0, 1'b0, 64'd5, 64'd9, 64'd45, 64, 2, 1'b1);

    // Flush in DONE drops out_valid but leaves result; flush beats start in IDLE
    mdu_if.op = 3'd7; mdu_if.is_w = 1'b0; mdu_if.src1 = 64'd77; mdu_if.src2 = 64'd0;
    mdu_if.start = 1'b1;
    step();
    mdu_if.start = 1'b0;
    chk("dz_remu.valid", {63'd0, mdu_if.out_valid}, 64'd1);
    chk("dz_remu.result", mdu_if.result, 64'd77);
    mdu_if.flush = 1'b1;
    step();
    chk("flush_done.state", {62'd0, mdu_if.busy, mdu_if.out_valid}, 64'd0);
    chk("flush_done.result", mdu_if.result, 64'd77);
    mdu_if.start = 1'b1;
    mdu_if.op = 3'd0;
    step();
    mdu_if.start = 1'b0;
    mdu_if.flush = 1'b0;
    chk("flush_vs_start.busy", {63'd0, mdu_if.busy}, 64'd0);

    // Reset pulled mid-divide abandons it immediately
    mdu_if.op = 3'd4; mdu_if.src1 = 64'd1000; mdu_if.src2 = 64'd7;
    mdu_if.start = 1'b1;
    step();
    mdu_if.start = 1'b0;
    repeat (10) step();
    #1 rst = 1'b0;
    #1;
    chk("rst_mid.busy", {63'd0, mdu_if.busy}, 64'd0);
    chk("rst_mid.out_valid", {63'd0, mdu_if.out_valid}, 64'd0);
    chk("rst_mid.result", mdu_if.result, 64'd0);
    #1 rst = 1'b1;
    run_op("after_rst", 3'd4, 1'b0, 64'd1000, 64'd7, 64'd142, 64, 0, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_w  = (r_op == 3'd0 || r_op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      r_a  = pick();
      r_b  = pick();
      model(r_op, r_w, r_a, r_b, r_exp, r_lat);
      run_op($sformatf("rnd%0d_op%0d_w%0d", i, r_op, r_w), r_op, r_w, r_a, r_b,
             r_exp, r_lat, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_mdu_ctrl.md
YSYX_220066_MDU_CTRL -- requirements
Module: ysyx_220066_mdu_ctrl

Interface
REQ-001 Parameter XLEN, default 64, datapath width; the only supported value is 64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; it clears the block immediately when low.
REQ-004 start  input  1  EX request to begin a mul/div operation; sampled only in IDLE.
REQ-005 flush  input  1  pipeline kill from raise_intr or a redirect; aborts any operation.
REQ-006 op  input  3  RV-M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 is_w  input  1  word variant (MULW/DIVW/DIVUW/REMW/REMUW).
REQ-008 src1  input  64  rs1 operand (multiplicand / dividend).
REQ-009 src2  input  64  rs2 operand (multiplier / divisor).
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 busy  output  1  high whenever state is not IDLE; drives the EX block/stall.
REQ-012 out_valid  output  1  result valid; held until accepted.
REQ-013 result  output  64  final result, registered.

Function
REQ-014 FSM states: IDLE, MUL, DIV, DONE; 7-bit iteration counter cnt.
REQ-015 IDLE with start=1 and flush=0 SHALL latch op, is_w and operands, and move to MUL (op[2]=0) or DIV (op[2]=1); cnt is set to 64, or to 32 when is_w=1.
REQ-016 Word operands: signed ops sign-extend src[31:0]; unsigned ops zero-extend src[31:0]; the final result is sign-extended from bit 31.
REQ-017 MUL/DIV state: one radix-2 shift-add / restoring-subtract step per cycle on operand magnitudes; cnt decrements; at cnt=1 the step completes, sign correction is applied and the state moves to DONE.
REQ-018 Latency: start accepted at edge E0; out_valid rises after edge E64 (E32 when is_w=1); busy is high from E0 to the acceptance edge.
REQ-019 MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64] under signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
REQ-020 Divide by zero: DIV/DIVU return all-ones (32 ones sign-extended when is_w=1); REM/REMU return the dividend; the block goes directly to DONE, with out_valid one cycle after start.
REQ-021 Signed overflow (dividend = most negative, divisor = -1): DIV returns the dividend and REM returns 0; the block goes directly to DONE.
REQ-022 Remainder sign follows the dividend; quotient is negated when the operand signs differ; truncation is toward zero.
REQ-023 DONE: out_valid=1 and result is stable; on out_ready=1 the block returns to IDLE at that edge, and busy and out_valid drop.
REQ-024 A new start is never accepted in the same cycle as DONE acceptance; start is honored only in IDLE.
REQ-025 start is ignored while busy; no re-latch occurs and no error is raised.
REQ-026 flush=1 in any state SHALL force IDLE at the next edge, clear out_valid and discard partial state; flush beats start and out_ready in the same cycle.
REQ-027 result SHALL only change when entering DONE.

Reset
REQ-028 While rst=0: state=IDLE, cnt=0, busy=0, out_valid=0, result=0, all internal registers 0; reset asserted mid-operation abandons the operation with no output.
REQ-029 After rst deasserts, the block accepts start at the first rising edge.

Verification
REQ-030 MUL src1=7, src2=-3 (64-bit), out_ready=1 -> out_valid exactly 64 cycles after start, result=0xFFFFFFFFFFFFFFEB; busy high throughout.
REQ-031 MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE; MULHSU src1=-1, src2=2 -> result=0xFFFFFFFFFFFFFFFF.
REQ-032 DIVW src1=0x80000000, src2=0xFFFFFFFF -> out_valid one cycle after start, result=0xFFFFFFFF80000000; REMW with the same operands -> result=0.
REQ-033 DIVU src2=0 -> result=all ones after 1 cycle; REM src1=-7, src2=2 -> result=-1 after 64 cycles; DIV src1=-7, src2=2 -> result=-3.
REQ-034 Start MUL, assert flush at cycle 20 -> IDLE at the next edge, out_valid never rises; a new start 1 cycle later completes normally; start pulses during busy do not alter result.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and result held stable, busy=1; pull rst low mid-DIV -> busy=0 and out_valid=0 immediately.
